// File: rtl/breath_envelope.sv
// Brightness envelope generator: produces a PWM duty word that ramps, holds
// or blinks, and only hands a new value to the PWM stage at its period start.
module breath_envelope #(
  parameter int unsigned DUTY_W   = 14,
  parameter int unsigned PERIOD   = 10000,
  parameter int unsigned STEP_DIV = 10000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        mode,
  input  logic [DUTY_W-1:0] step,
  input  logic [7:0]        hold_hi,
  input  logic [7:0]        hold_lo,
  input  logic              pwm_sync,
  output logic [DUTY_W-1:0] duty,
  output logic              duty_valid,
  output logic [2:0]        phase,
  output logic              cycle_done
);

  localparam int unsigned PS_W  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int unsigned SUM_W = DUTY_W + 1;
  localparam int unsigned HLD_W = 8;

  localparam logic [PS_W-1:0]   PS_LAST  = PS_W'(STEP_DIV - 1);
  localparam logic [DUTY_W-1:0] LVL_MAX  = DUTY_W'(PERIOD);
  localparam logic [SUM_W-1:0]  SUM_MAX  = SUM_W'(PERIOD);
  localparam logic [HLD_W-1:0]  HLD_ONE  = HLD_W'(1);

  localparam logic [1:0] MODE_OFF     = 2'd0;
  localparam logic [1:0] MODE_ON      = 2'd1;
  localparam logic [1:0] MODE_BREATHE = 2'd2;
  localparam logic [1:0] MODE_BLINK   = 2'd3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RISE    = 3'd1,
    HOLD_HI = 3'd2,
    FALL    = 3'd3,
    HOLD_LO = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [DUTY_W-1:0]  level_q, level_d;
  logic [HLD_W-1:0]   hold_q, hold_d;
  logic [1:0]         mode_q;
  logic [PS_W-1:0]    ps_q;
  logic               cycle_done_d;
  logic               tick;
  logic [SUM_W-1:0]   rise_sum;

  assign tick  = (ps_q == PS_LAST);
  assign phase = state_q;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, next level/hold and end-of-cycle pulse; mode change beats tick
  always_comb begin
    state_d      = state_q;
    level_d      = level_q;
    hold_d       = hold_q;
    cycle_done_d = 1'b0;
    rise_sum     = {1'b0, level_q} + {1'b0, step};

    if (mode != mode_q) begin
      case (mode)
        MODE_OFF: begin
          state_d = IDLE;
          level_d = '0;
        end
        MODE_ON: begin
          state_d = IDLE;
          level_d = LVL_MAX;
        end
        MODE_BREATHE: begin
          state_d = RISE;
          level_d = '0;
        end
        default: begin
          state_d = HOLD_HI;
          level_d = LVL_MAX;
          hold_d  = hold_hi;
        end
      endcase
    end else if (tick) begin
      case (state_q)
        RISE: begin
          if (rise_sum >= SUM_MAX) begin
            level_d = LVL_MAX;
            state_d = HOLD_HI;
            hold_d  = hold_hi;
          end else begin
            level_d = rise_sum[DUTY_W-1:0];
          end
        end
        HOLD_HI: begin
          if (hold_q == '0) begin
            if (mode == MODE_BREATHE) begin
              state_d = FALL;
            end else begin
              level_d = '0;
              state_d = HOLD_LO;
              hold_d  = hold_lo;
            end
          end else begin
            hold_d = hold_q - HLD_ONE;
          end
        end
        FALL: begin
          if (step >= level_q) begin
            level_d = '0;
            state_d = HOLD_LO;
            hold_d  = hold_lo;
          end else begin
            level_d = level_q - step;
          end
        end
        HOLD_LO: begin
          if (hold_q == '0) begin
            cycle_done_d = 1'b1;
            if (mode == MODE_BREATHE) begin
              state_d = RISE;
            end else begin
              level_d = LVL_MAX;
              state_d = HOLD_HI;
              hold_d  = hold_hi;
            end
          end else begin
            hold_d = hold_q - HLD_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  // Envelope datapath, free-running prescaler and registered pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level_q    <= '0;
      hold_q     <= '0;
      mode_q     <= MODE_OFF;
      ps_q       <= '0;
      cycle_done <= 1'b0;
    end else begin
      level_q    <= level_d;
      hold_q     <= hold_d;
      mode_q     <= mode;
      ps_q       <= tick ? '0 : ps_q + PS_W'(1);
      cycle_done <= cycle_done_d;
    end
  end

  // Duty shadow: captures the pre-edge level only at PWM period start
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      duty       <= '0;
      duty_valid <= 1'b0;
    end else begin
      duty_valid <= pwm_sync;
      if (pwm_sync) begin
        duty <= level_q;
      end
    end
  end

endmodule

// File: tb/tb_breath_envelope.sv
// Self-checking bench for breath_envelope against a cycle-level behavioural model.
module tb_breath_envelope;

  localparam int unsigned DUTY_W   = 8;
  localparam int unsigned PERIOD   = 100;
  localparam int unsigned STEP_DIV = 4;
  localparam int PER = int'(PERIOD);

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0]        mode;
  logic [DUTY_W-1:0] step;
  logic [7:0]        hold_hi;
  logic [7:0]        hold_lo;
  logic              pwm_sync;
  logic [DUTY_W-1:0] duty;
  logic              duty_valid;
  logic [2:0]        phase;
  logic              cycle_done;

  int checks   = 0;
  int failures = 0;

  // Model state, named after the specification's phases
  int m_ps, m_level, m_hold, m_modeq, m_phase, m_duty, m_dv, m_cd;
  int cyc_no = 0;

  breath_envelope #(.DUTY_W(DUTY_W), .PERIOD(PERIOD), .STEP_DIV(STEP_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .step(step),
    .hold_hi(hold_hi), .hold_lo(hold_lo), .pwm_sync(pwm_sync),
    .duty(duty), .duty_valid(duty_valid), .phase(phase), .cycle_done(cycle_done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One rising edge of the envelope, straight from the behavioural rules
  function automatic void model_edge();
    int md, st, hh, hl;
    bit tk;
    md = int'(mode); st = int'(step); hh = int'(hold_hi); hl = int'(hold_lo);
    if (!rst_n) begin
      m_ps = 0; m_level = 0; m_hold = 0; m_modeq = 0;
      m_phase = 0; m_duty = 0; m_dv = 0; m_cd = 0;
      return;
    end
    tk = (m_ps == int'(STEP_DIV) - 1);
    m_dv = pwm_sync ? 1 : 0;
    if (pwm_sync) m_duty = m_level;
    m_cd = 0;
    if (md != m_modeq) begin
      case (md)
        0: begin m_phase = 0; m_level = 0; end
        1: begin m_phase = 0; m_level = PER; end
        2: begin m_phase = 1; m_level = 0; end
        default: begin m_phase = 2; m_level = PER; m_hold = hh; end
      endcase
    end else if (tk) begin
      case (m_phase)
        1: if (m_level + st >= PER) begin
             m_level = PER; m_phase = 2; m_hold = hh;
           end else m_level = m_level + st;
        2: if (m_hold == 0) begin
             if (md == 2) m_phase = 3;
             else begin m_level = 0; m_phase = 4; m_hold = hl; end
           end else m_hold--;
        3: if (st >= m_level) begin
             m_level = 0; m_phase = 4; m_hold = hl;
           end else m_level = m_level - st;
        4: if (m_hold == 0) begin
             m_cd = 1;
             if (md == 2) m_phase = 1;
             else begin m_level = PER; m_phase = 2; m_hold = hh; end
           end else m_hold--;
        default: ;
      endcase
    end
    m_modeq = md;
    m_ps = (m_ps + 1) % int'(STEP_DIV);
  endfunction

  // Advance one clock, update the model, then compare away from the edge
  task automatic clk_cycle();
    @(posedge clk);
    model_edge();
    cyc_no++;
    #1;
    check_eq("duty", int'(duty), m_duty);
    check_eq("duty_valid", int'(duty_valid), m_dv);
    check_eq("phase", int'(phase), m_phase);
    check_eq("cycle_done", int'(cycle_done), m_cd);
    check_eq("duty_range", (int'(duty) <= PER) ? 1 : 0, 1);
  endtask

  task automatic run(input int n, input int sync_every);
    for (int i = 0; i < n; i++) begin
      pwm_sync = (sync_every <= 1) ? 1'b1 : ((cyc_no % sync_every) == 0);
      clk_cycle();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; mode = 2'd0; pwm_sync = 1'b1;
    clk_cycle();
    clk_cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    int last_cd;
    bit found;
    rst_n = 1'b0; mode = 2'd0; step = '0; hold_hi = '0; hold_lo = '0; pwm_sync = 1'b1;

    // Reset state
    do_reset();
    check_eq("rst_duty", int'(duty), 0);
    check_eq("rst_phase", int'(phase), 0);
    check_eq("rst_valid", int'(duty_valid), 0);
    check_eq("rst_cdone", int'(cycle_done), 0);

    // Breathe, step 30, no holds
    step = 8'd30; hold_hi = 8'd0; hold_lo = 8'd0; mode = 2'd2;
    run(120, 1);

    // Blink, hold_hi=2, hold_lo=0: cycle_done every 16 clocks
    mode = 2'd3; hold_hi = 8'd2;
    last_cd = -1;
    for (int i = 0; i < 100; i++) begin
      pwm_sync = 1'b1;
      clk_cycle();
      if (cycle_done) begin
        if (last_cd >= 0) check_eq("blink_cd_spacing", cyc_no - last_cd, 16);
        last_cd = cyc_no;
      end
    end
    check_eq("blink_cd_seen", (last_cd >= 0) ? 1 : 0, 1);

    // Breathe with pwm_sync every 10 clocks
    mode = 2'd2; hold_hi = 8'd1; hold_lo = 8'd1; step = 8'd30;
    run(200, 10);

    // Mode change mid-RISE: on then off, no tick needed
    mode = 2'd0; run(2, 1);
    mode = 2'd2; step = 8'd30; hold_hi = 8'd0; hold_lo = 8'd0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      pwm_sync = 1'b1;
      clk_cycle();
      if (m_phase == 1 && m_level == 60) found = 1'b1;
    end
    check_eq("reach_rise60", int'(found), 1);
    mode = 2'd1; run(1, 1);
    check_eq("on_phase", int'(phase), 0);
    run(1, 1);
    check_eq("on_duty", int'(duty), 100);
    mode = 2'd0; run(1, 1);
    check_eq("off_phase", int'(phase), 0);
    run(1, 1);
    check_eq("off_duty", int'(duty), 0);

    // Reset mid-FALL at level 40, then re-entry into RISE
    mode = 2'd2; step = 8'd30;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      pwm_sync = 1'b1;
      clk_cycle();
      if (m_phase == 3 && m_level == 40) found = 1'b1;
    end
    check_eq("reach_fall40", int'(found), 1);
    rst_n = 1'b0; clk_cycle();
    check_eq("midrst_duty", int'(duty), 0);
    check_eq("midrst_phase", int'(phase), 0);
    check_eq("midrst_valid", int'(duty_valid), 0);
    check_eq("midrst_cdone", int'(cycle_done), 0);
    rst_n = 1'b1; run(1, 1);
    check_eq("rerise_phase", int'(phase), 1);
    run(40, 1);

    // Oversized step saturates both ways
    mode = 2'd0; run(1, 1);
    step = 8'd250; mode = 2'd2;
    run(80, 1);

    // Randomized soak: mode changes, step/hold changes, sparse sync, resets
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) begin
        case ($urandom_range(0, 3))
          0: step = 8'd0;
          1: step = 8'd250;
          default: step = 8'($urandom_range(1, 120));
        endcase
      end
      if ($urandom_range(0, 29) == 0) hold_hi = 8'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) hold_lo = 8'($urandom_range(0, 3));
      pwm_sync = ($urandom_range(0, 2) == 0);
      clk_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/breath_envelope.md
Name: breath_envelope

Overview:
Upstream brightness-envelope generator for the LED PWM stage. It produces a duty word in the range 0..PERIOD. The PWM stage compares this word against its own period counter. The envelope supports off, on, breathe and blink modes, with configurable ramp step and hold times. The duty output changes only on the PWM stage's period-start pulse, so the PWM stage never sees a mid-period duty change.

Parameters:
DUTY_W, 14, width of the duty/level word; must satisfy 2^DUTY_W > PERIOD
PERIOD, 10000, PWM period in clocks; full-brightness duty value
STEP_DIV, 10000, clocks per envelope tick (200 us at 50 MHz)

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous reset, active low
mode  input  2  0=off, 1=on, 2=breathe, 3=blink
step  input  DUTY_W  level increment/decrement per tick in breathe mode
hold_hi  input  8  extra ticks held at PERIOD (HOLD_HI state)
hold_lo  input  8  extra ticks held at 0 (HOLD_LO state)
pwm_sync  input  1  one-clock pulse from the PWM stage at period start
duty  output  DUTY_W  registered duty word for the PWM stage
duty_valid  output  1  one-clock pulse when duty is loaded
phase  output  3  FSM state: 0 IDLE, 1 RISE, 2 HOLD_HI, 3 FALL, 4 HOLD_LO
cycle_done  output  1  one-clock pulse at the end of each HOLD_LO

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous and active-low. All state is sampled only on the rising edge of clk.
- Reset (rst_n low at an edge):
  - Outputs: duty=0, duty_valid=0, cycle_done=0, phase=IDLE.
  - Internal: level=0, prescaler=0, hold counter=0, mode_q=0.
  - A reset asserted mid-operation aborts the current ramp; no pulses are emitted.
- Prescaler:
  - Free-running, counts 0..STEP_DIV-1 and wraps.
  - tick is high for one clock when prescaler==STEP_DIV-1.
  - Only reset clears the prescaler; a mode change does not.
- Mode change:
  - mode_q holds the previously sampled mode.
  - When mode != mode_q at an edge, that same edge applies the following, regardless of tick:
    - off: phase=IDLE, level=0.
    - on: phase=IDLE, level=PERIOD.
    - breathe: phase=RISE, level=0.
    - blink: phase=HOLD_HI, level=PERIOD, hold counter=hold_hi.
- IDLE: level stays where the mode change left it; tick is ignored.
- RISE, on tick:
  - Compute level+step at DUTY_W+1 bits.
  - If the result is >= PERIOD: level=PERIOD, go to HOLD_HI, hold counter=hold_hi.
  - Otherwise: level=level+step.
- HOLD_HI, on tick:
  - If hold counter==0: leave the state. In breathe mode go to FALL. In blink mode set level=0, go to HOLD_LO, hold counter=hold_lo.
  - Otherwise: decrement the hold counter.
  - Dwell is hold_hi+1 ticks.
- FALL, on tick:
  - If step >= level: level=0, go to HOLD_LO, hold counter=hold_lo.
  - Otherwise: level=level-step.
- HOLD_LO, on tick:
  - If hold counter==0: pulse cycle_done for one clock. In breathe mode go to RISE (level stays 0). In blink mode set level=PERIOD, go to HOLD_HI, hold counter=hold_hi.
  - Otherwise: decrement the hold counter.
- step==0 in breathe: level never changes and the FSM stays in RISE or FALL. This is legal and must not lock up the block; a mode change recovers it.
- step, hold_hi and hold_lo are sampled at use time, so changing them takes effect at the next tick or hold load.
- Duty shadow:
  - On an edge with pwm_sync=1: duty=level (the pre-edge register value), and duty_valid=1 for one clock.
  - Otherwise duty holds and duty_valid=0.
  - When pwm_sync coincides with a tick or a mode change, duty takes the old level; the new level appears at the next pwm_sync.
  - Latency: level to duty is 0..1 PWM period; duty is valid 1 clock after pwm_sync is sampled.
- duty never exceeds PERIOD.
- Expected implementation size: 150-250 lines of RTL.

Test Plan:
Common bench parameters: PERIOD=100, STEP_DIV=4, DUTY_W=8. pwm_sync is pulsed every clock unless stated otherwise.
1. Breathe, step=30, hold_hi=0, hold_lo=0 -> per tick: level 30,60,90,100 (HOLD_HI, 1 tick), then 70,40,10,0 (HOLD_LO, 1 tick), then cycle_done pulses once and phase=RISE.
2. Blink, hold_hi=2, hold_lo=0 -> duty=100 for 3 ticks (12 clks), then duty=0 for 1 tick (4 clks), repeating; cycle_done pulses every 16 clks.
3. Breathe with pwm_sync every 10 clks -> duty changes only on the clock after each pwm_sync and duty_valid pulses exactly then; duty is never seen at an intermediate value between pulses.
4. Breathe at level=60 in RISE, switch mode to on -> next edge: level=100, phase=IDLE; switch to off -> level=0, phase=IDLE; both happen with no tick required.
5. Breathe mid-FALL at level=40, hold rst_n low for 1 edge -> duty=0, phase=IDLE, duty_valid=0, cycle_done=0. After release with mode=2 held, the FSM stays IDLE until the mode changes (mode_q was reset to 0, so the first edge sees a change and enters RISE with level=0).
6. Breathe, step=250 (greater than PERIOD) -> level saturates to 100 on the first tick, then to 0 on the first FALL tick; no wrap-around value (e.g. 250 or 150) ever appears on duty.
